uart_transmitter: RTL and testbench

UART_TRANSMITTER -- requirements
Module: uart_transmitter

---
 rtl/uart_transmitter_pkg.sv | 21 ++
 rtl/uart_transmitter_baud_tick_gen.sv | 27 ++
 rtl/uart_transmitter.sv | 87 ++++++++
 tb/tb_uart_transmitter.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/uart_transmitter_pkg.sv
// Shared UART definitions: FSM state encoding and frame geometry,
// used by both the transmitter and the receiver.
package uart_transmitter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = DATA_BITS + 2;
  localparam int BIT_W      = $clog2(DATA_BITS);

  // A one-cycle bit period still needs a one-bit counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_transmitter_baud_tick_gen.sv
// Free-running bit-period counter with a synchronous clear; emits a
// one-cycle tick on the last cycle of every SYMBOL_EDGE_TIME-cycle period.
module baud_tick_gen #(
  parameter int SYMBOL_EDGE_TIME = 10,
  parameter int CNT_W            = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic clear_i,
  output logic tick_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CNT_W'(SYMBOL_EDGE_TIME - 1));

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clear_i || tick_o) cnt_d = '0;
  end

  always_ff @(posedge clk) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_transmitter.sv
// 8N1 UART transmitter with a valid/ready byte interface. The line is
// driven straight from bit 0 of the frame shift register.
module uart_transmitter
  import uart_transmitter_pkg::*;
#(
  parameter int CLOCK_FREQ = 50_000_000,
  parameter int BAUD_RATE  = 115_200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] data_in,
  input  logic       data_in_valid,
  output logic       data_in_ready,
  output logic       serial_out
);

  localparam int SYMBOL_EDGE_TIME = CLOCK_FREQ / BAUD_RATE;
  localparam int CNT_W            = cnt_width(SYMBOL_EDGE_TIME);

  uart_state_e           state_q, state_d;
  logic [BIT_W-1:0]      bit_q, bit_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic                  tick;

  // Holding the counter clear while idle means it starts from 0 on accept.
  baud_tick_gen #(
    .SYMBOL_EDGE_TIME(SYMBOL_EDGE_TIME),
    .CNT_W           (CNT_W)
  ) u_baud (
    .clk    (clk),
    .rst    (rst),
    .clear_i(state_q == IDLE),
    .tick_o (tick)
  );

  assign data_in_ready = (state_q == IDLE);
  assign serial_out    = shift_q[0];

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    unique case (state_q)
      IDLE: begin
        if (data_in_valid) begin
          shift_d = {1'b1, data_in, 1'b0};
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (tick) begin
          shift_d = {1'b1, shift_q[FRAME_BITS-1:1]};
          bit_d   = '0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (tick) begin
          shift_d = {1'b1, shift_q[FRAME_BITS-1:1]};
          if (bit_q == BIT_W'(DATA_BITS - 1)) state_d = STOP;
          else                                bit_d   = bit_q + 1'b1;
        end
      end
      STOP: begin
        if (tick) begin
          shift_d = {1'b1, shift_q[FRAME_BITS-1:1]};
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      bit_q   <= '0;
      shift_q <= '1;
    end else begin
      state_q <= state_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Directed bench for uart_transmitter at 10 clocks per bit; every expected
// line level is built from the byte being sent, sampled 1 time unit after each edge.
module tb_uart_transmitter;

  localparam int BIT_CYC   = 10;
  localparam int FRAME_CYC = 100;

  logic       clk;
  logic       rst;
  logic [7:0] data_in;
  logic       data_in_valid;
  logic       data_in_ready;
  logic       serial_out;

  int checks = 0;
  int errors = 0;
  int cycleCnt = 0;
  int acceptCycle;
  logic [7:0] txByte;
  logic [7:0] rxByte;

  uart_transmitter #(
    .CLOCK_FREQ(1000),
    .BAUD_RATE (100)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .data_in      (data_in),
    .data_in_valid(data_in_valid),
    .data_in_ready(data_in_ready),
    .serial_out   (serial_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt++;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic [7:0] d);
    data_in_valid = v;
    data_in       = d;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called just after the accept edge; checks nCycles of the frame line.
  task automatic checkFrame(input logic [7:0] b, input bit toggle, input int nCycles, input string tag);
    logic [9:0] f;
    f = {1'b1, b, 1'b0};
    for (int k = 0; k < nCycles; k++) begin
      checkOutput({tag, "_line"}, {31'd0, serial_out}, {31'd0, f[k / BIT_CYC]});
      checkOutput({tag, "_ready"}, {31'd0, data_in_ready}, 32'd0);
      if (toggle) applyStimulus(1'b1, k[0] ? 8'h3C : 8'hC3);
      tick();
    end
  endtask

  initial begin
    rst = 1'b0;
    applyStimulus(1'b1, 8'h00);
    // Reset held with valid high: nothing may be accepted.
    tick();
    checkOutput("rst_line", {31'd0, serial_out}, 32'd1);
    checkOutput("rst_ready", {31'd0, data_in_ready}, 32'd1);
    tick();
    checkOutput("rst_line2", {31'd0, serial_out}, 32'd1);
    applyStimulus(1'b0, 8'h00);
    rst = 1'b1;
    tick();
    checkOutput("post_rst_line", {31'd0, serial_out}, 32'd1);
    checkOutput("post_rst_ready", {31'd0, data_in_ready}, 32'd1);

    $display("[TB] idle 500 cycles");
    for (int k = 0; k < 500; k++) begin
      checkOutput("idle_line", {31'd0, serial_out}, 32'd1);
      checkOutput("idle_ready", {31'd0, data_in_ready}, 32'd1);
      tick();
    end

    $display("[TB] single frame 0xA5");
    applyStimulus(1'b1, 8'hA5);
    tick();
    applyStimulus(1'b0, 8'h00);
    checkFrame(8'hA5, 1'b0, FRAME_CYC, "a5");
    checkOutput("a5_end_ready", {31'd0, data_in_ready}, 32'd1);
    checkOutput("a5_end_line", {31'd0, serial_out}, 32'd1);
    tick();

    $display("[TB] back-to-back 0x00 / 0xFF");
    applyStimulus(1'b1, 8'h00);
    tick();
    acceptCycle = cycleCnt;
    applyStimulus(1'b1, 8'hFF);
    checkFrame(8'h00, 1'b0, FRAME_CYC, "b2b0");
    checkOutput("b2b_gap_ready", {31'd0, data_in_ready}, 32'd1);
    tick();
    applyStimulus(1'b0, 8'h00);
    checkFrame(8'hFF, 1'b0, FRAME_CYC, "b2b1");
    checkOutput("b2b_total", cycleCnt - acceptCycle, 32'd201);
    checkOutput("b2b_end_ready", {31'd0, data_in_ready}, 32'd1);
    tick();

    $display("[TB] data changes mid-frame");
    applyStimulus(1'b1, 8'h55);
    tick();
    checkFrame(8'h55, 1'b1, FRAME_CYC, "tog55");
    applyStimulus(1'b1, 8'hC3);
    checkOutput("tog_ready", {31'd0, data_in_ready}, 32'd1);
    tick();
    applyStimulus(1'b0, 8'h00);
    checkFrame(8'hC3, 1'b0, FRAME_CYC, "togC3");
    tick();

    $display("[TB] reset during data bit 3");
    applyStimulus(1'b1, 8'h81);
    tick();
    applyStimulus(1'b0, 8'h00);
    checkFrame(8'h81, 1'b0, 45, "abort81");
    rst = 1'b0;
    tick();
    checkOutput("abort_line", {31'd0, serial_out}, 32'd1);
    checkOutput("abort_ready", {31'd0, data_in_ready}, 32'd1);
    rst = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("abort_idle_line", {31'd0, serial_out}, 32'd1);
      checkOutput("abort_idle_ready", {31'd0, data_in_ready}, 32'd1);
    end
    applyStimulus(1'b1, 8'h7E);
    tick();
    applyStimulus(1'b0, 8'h00);
    checkFrame(8'h7E, 1'b0, FRAME_CYC, "after7E");
    checkOutput("after7E_ready", {31'd0, data_in_ready}, 32'd1);

    $display("[TB] 256 random bytes, mid-bit decode");
    for (int n = 0; n < 256; n++) begin
      txByte = 8'($urandom_range(0, 255));
      applyStimulus(1'b1, txByte);
      checkOutput("rand_ready", {31'd0, data_in_ready}, 32'd1);
      tick();
      applyStimulus(1'b0, 8'h00);
      rxByte = '0;
      for (int k = 0; k < FRAME_CYC; k++) begin
        if (k % BIT_CYC == 5) begin
          if (k == 5)       checkOutput("rand_start", {31'd0, serial_out}, 32'd0);
          else if (k == 95) checkOutput("rand_stop", {31'd0, serial_out}, 32'd1);
          else              rxByte[k / BIT_CYC - 1] = serial_out;
        end
        tick();
      end
      checkOutput("rand_byte", {24'd0, rxByte}, {24'd0, txByte});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
